// File: rtl/rr_arbiter_router_pkg.sv
// Shared widths, FSM encoding and word-field helpers for the round-robin
// input-to-output FIFO router.
package router_pkg;

  localparam int DATA_W    = 10;
  localparam int DEST_W    = 2;
  localparam int LIM_W     = 3;
  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  // Destination output port is carried in the top bits of every word.
  function automatic logic [DEST_W-1:0] dest_of(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: DEST_W];
  endfunction

endpackage

// File: rtl/rr_arbiter_router_if.sv
// FIFO-side bus of the router: input FIFO heads/pops, output FIFO pushes,
// back-pressure and the threshold configuration.
interface rr_arbiter_router_if;
  import router_pkg::*;

  logic                 init;
  logic [LIM_W-1:0]     limit_low;
  logic [LIM_W-1:0]     limit_high;
  logic [NUM_PORTS-1:0] in_empty;
  logic [DATA_W-1:0]    data0_in;
  logic [DATA_W-1:0]    data1_in;
  logic [DATA_W-1:0]    data2_in;
  logic [DATA_W-1:0]    data3_in;
  logic [NUM_PORTS-1:0] pop_in;
  logic [NUM_PORTS-1:0] out_almost_full;
  logic [DATA_W-1:0]    data_out;
  logic [NUM_PORTS-1:0] push_out;
  logic [LIM_W-1:0]     thr_low;
  logic [LIM_W-1:0]     thr_high;
  logic                 idle;

  modport slave (
    input  init, limit_low, limit_high, in_empty,
    input  data0_in, data1_in, data2_in, data3_in, out_almost_full,
    output pop_in, data_out, push_out, thr_low, thr_high, idle
  );

  modport master (
    output init, limit_low, limit_high, in_empty,
    output data0_in, data1_in, data2_in, data3_in, out_almost_full,
    input  pop_in, data_out, push_out, thr_low, thr_high, idle
  );

endinterface

// File: rtl/rr_arbiter_router_rr_grant.sv
// Combinational 4-way round-robin picker: first requester at or after ptr_i
// wins, so a blocked queue never stalls the others.
module rr_grant
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [DEST_W-1:0]    ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [DEST_W-1:0]    idx_o,
  output logic                 vld_o
);

  logic [DEST_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = ptr_i + DEST_W'(k);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_router.sv
// Central switch: pops input FIFOs 0-3 in round-robin order and pushes each
// word one cycle later into the output FIFO named by its destination field.
module rr_arbiter_router
  import router_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  rr_arbiter_router_if.slave  bus
);

  state_e               state_q, state_d;
  logic [DEST_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [NUM_PORTS-1:0] push_q, push_d;
  logic [LIM_W-1:0]     thr_low_q, thr_low_d;
  logic [LIM_W-1:0]     thr_high_q, thr_high_d;

  logic [DATA_W-1:0]    head [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [DEST_W-1:0]    gnt_idx;
  logic                 gnt_vld;
  logic                 grant;
  logic                 any_valid;

  assign head[0] = bus.data0_in;
  assign head[1] = bus.data1_in;
  assign head[2] = bus.data2_in;
  assign head[3] = bus.data3_in;

  // A queue only requests if its head's destination can still accept a word.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = ~bus.in_empty[i] & ~bus.out_almost_full[dest_of(head[i])];
    end
  end

  rr_grant u_grant (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign grant     = (state_q == ST_ACTIVE) && !bus.init && gnt_vld;
  assign any_valid = ~&bus.in_empty;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    data_d     = data_q;
    push_d     = '0;
    thr_low_d  = thr_low_q;
    thr_high_d = thr_high_q;

    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        thr_low_d  = bus.limit_low;
        thr_high_d = bus.limit_high;
        if (!bus.init) state_d = any_valid ? ST_ACTIVE : ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.init)       state_d = ST_INIT;
        else if (any_valid) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init)                   state_d = ST_INIT;
        else if (!any_valid && !grant)  state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase

    if (grant) begin
      data_d   = head[gnt_idx];
      push_d   = NUM_PORTS'(1) << dest_of(head[gnt_idx]);
      rr_ptr_d = gnt_idx + DEST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      rr_ptr_q   <= '0;
      data_q     <= '0;
      push_q     <= '0;
      thr_low_q  <= '0;
      thr_high_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      data_q     <= data_d;
      push_q     <= push_d;
      thr_low_q  <= thr_low_d;
      thr_high_q <= thr_high_d;
    end
  end

  assign bus.pop_in   = grant ? gnt : '0;
  assign bus.data_out = data_q;
  assign bus.push_out = push_q;
  assign bus.thr_low  = thr_low_q;
  assign bus.thr_high = thr_high_q;
  assign bus.idle     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_rr_arbiter_router.sv
// Directed bench for rr_arbiter_router: reset, init latch, single word,
// round-robin stream, a back-pressure vector table, init/reset mid-stream.
module tb_rr_arbiter_router;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  rr_arbiter_router_if bus ();

  rr_arbiter_router dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] empty;
    logic [9:0] d0, d1, d2, d3;
    logic [3:0] af;
    logic [3:0] pop;
    logic [3:0] push;
    logic [9:0] dout;
  } vec_t;

  vec_t       vecs [12];
  logic [9:0] qm [4][$];
  logic [9:0] last_word;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] empty, input logic [9:0] d0, input logic [9:0] d1,
                       input logic [9:0] d2, input logic [9:0] d3, input logic [3:0] af);
    bus.in_empty        = empty;
    bus.data0_in        = d0;
    bus.data1_in        = d1;
    bus.data2_in        = d2;
    bus.data3_in        = d3;
    bus.out_almost_full = af;
  endtask

  task automatic drive_model();
    logic [9:0] h [4];
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      e[i] = (qm[i].size() == 0);
      h[i] = e[i] ? 10'h0 : qm[i][0];
    end
    drive(e, h[0], h[1], h[2], h[3], 4'b0000);
  endtask

  task automatic reset_to_idle();
    reset    = 1'b1;
    bus.init = 1'b0;
    drive(4'hF, 10'h0, 10'h0, 10'h0, 10'h0, 4'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("reinit_idle", int'(bus.idle), 1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.init       = 1'b0;
    bus.limit_low  = 3'd0;
    bus.limit_high = 3'd0;
    drive(4'hF, 10'h0, 10'h0, 10'h0, 10'h0, 4'h0);

    // Reset with random inputs on the bus.
    for (int c = 0; c < 3; c++) begin
      bus.init       = 1'($urandom);
      bus.limit_low  = 3'($urandom);
      bus.limit_high = 3'($urandom);
      drive(4'($urandom), 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom), 4'($urandom));
      tick();
      chk("rst_pop", int'(bus.pop_in), 0);
      chk("rst_push", int'(bus.push_out), 0);
      chk("rst_data", int'(bus.data_out), 0);
      chk("rst_thr_low", int'(bus.thr_low), 0);
      chk("rst_thr_high", int'(bus.thr_high), 0);
      chk("rst_idle", int'(bus.idle), 0);
    end

    // Init latch then fall to IDLE with all queues empty.
    reset          = 1'b0;
    bus.init       = 1'b1;
    bus.limit_low  = 3'd3;
    bus.limit_high = 3'd7;
    drive(4'hF, 10'h0, 10'h0, 10'h0, 10'h0, 4'h0);
    tick();
    tick();
    chk("init_idle_low", int'(bus.idle), 0);
    chk("init_thr_low", int'(bus.thr_low), 3);
    bus.init = 1'b0;
    tick();
    chk("init_to_idle", int'(bus.idle), 1);
    chk("init_thr_low2", int'(bus.thr_low), 3);
    chk("init_thr_high", int'(bus.thr_high), 7);

    // Single word from queue 2 to output 1.
    drive(4'b1011, 10'h0, 10'h0, 10'h1A5, 10'h0, 4'h0);
    #1 chk("single_pop_idle", int'(bus.pop_in), 0);
    tick();
    #1 chk("single_pop", int'(bus.pop_in), 4'b0100);
    tick();
    drive(4'hF, 10'h0, 10'h0, 10'h0, 10'h0, 4'h0);
    chk("single_push", int'(bus.push_out), 4'b0010);
    chk("single_data", int'(bus.data_out), 10'h1A5);
    #1 chk("single_pop_after", int'(bus.pop_in), 0);
    tick();
    chk("single_back_idle", int'(bus.idle), 1);
    chk("single_push_clr", int'(bus.push_out), 0);
    chk("single_data_hold", int'(bus.data_out), 10'h1A5);

    // Round-robin stream: 4 queues x 6 words, dest = queue index, rr_ptr = 0.
    reset_to_idle();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 6; k++)
        qm[i].push_back({2'(i), 8'(i * 16 + k)});
    drive_model();
    tick();
    last_word = 10'h0;
    for (int c = 0; c < 24; c++) begin
      drive_model();
      if (c > 0) begin
        chk("rr_push", int'(bus.push_out), 1 << last_word[9:8]);
        chk("rr_data", int'(bus.data_out), int'(last_word));
      end
      #1 chk("rr_pop", int'(bus.pop_in), 1 << (c % 4));
      if (qm[c % 4].size() != 0) last_word = qm[c % 4].pop_front();
      tick();
    end
    drive_model();
    chk("rr_push_last", int'(bus.push_out), 4'b1000);
    chk("rr_data_last", int'(bus.data_out), 10'h335);
    tick();
    chk("rr_back_idle", int'(bus.idle), 1);
    chk("rr_push_clr", int'(bus.push_out), 0);

    // Back-pressure and skip vectors, rr_ptr starts at 0 in IDLE.
    vecs[0]  = '{4'b1100, 10'h3AA, 10'h155, 10'h000, 10'h000, 4'b1000, 4'b0000, 4'b0000, 10'h335};
    vecs[1]  = '{4'b1100, 10'h3AA, 10'h155, 10'h000, 10'h000, 4'b1000, 4'b0010, 4'b0010, 10'h155};
    vecs[2]  = '{4'b1110, 10'h3AA, 10'h000, 10'h000, 10'h000, 4'b1000, 4'b0000, 4'b0000, 10'h155};
    vecs[3]  = '{4'b1110, 10'h3AA, 10'h000, 10'h000, 10'h000, 4'b0000, 4'b0001, 4'b1000, 10'h3AA};
    vecs[4]  = '{4'b1010, 10'h0C3, 10'h000, 10'h2F0, 10'h000, 4'b0000, 4'b0100, 4'b0100, 10'h2F0};
    vecs[5]  = '{4'b1110, 10'h0C3, 10'h000, 10'h000, 10'h000, 4'b0001, 4'b0000, 4'b0000, 10'h2F0};
    vecs[6]  = '{4'b1110, 10'h0C3, 10'h000, 10'h000, 10'h000, 4'b0010, 4'b0001, 4'b0001, 10'h0C3};
    vecs[7]  = '{4'b0000, 10'h100, 10'h201, 10'h302, 10'h003, 4'b0100, 4'b0100, 4'b1000, 10'h302};
    vecs[8]  = '{4'b0000, 10'h100, 10'h201, 10'h302, 10'h003, 4'b0100, 4'b1000, 4'b0001, 10'h003};
    vecs[9]  = '{4'b0000, 10'h100, 10'h201, 10'h302, 10'h003, 4'b1111, 4'b0000, 4'b0000, 10'h003};
    vecs[10] = '{4'b0000, 10'h100, 10'h201, 10'h302, 10'h003, 4'b0000, 4'b0001, 4'b0010, 10'h100};
    vecs[11] = '{4'b1111, 10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 4'b0000, 4'b0000, 10'h100};
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].empty, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].af);
      #1 chk($sformatf("vec%0d_pop", v), int'(bus.pop_in), int'(vecs[v].pop));
      tick();
      chk($sformatf("vec%0d_push", v), int'(bus.push_out), int'(vecs[v].push));
      chk($sformatf("vec%0d_data", v), int'(bus.data_out), int'(vecs[v].dout));
    end
    chk("vec_back_idle", int'(bus.idle), 1);

    // Init mid-stream: rr_ptr = 1, pending push completes, pops stop.
    bus.limit_low  = 3'd5;
    bus.limit_high = 3'd6;
    drive(4'b0000, 10'h0A0, 10'h1A1, 10'h2A2, 10'h3A3, 4'h0);
    tick();
    #1 chk("mid_pop_first", int'(bus.pop_in), 4'b0010);
    tick();
    bus.init = 1'b1;
    chk("mid_push_done", int'(bus.push_out), 4'b0010);
    chk("mid_data_done", int'(bus.data_out), 10'h1A1);
    #1 chk("mid_pop_init_seen", int'(bus.pop_in), 0);
    tick();
    chk("mid_push_stop", int'(bus.push_out), 0);
    #1 chk("mid_pop_in_init", int'(bus.pop_in), 0);
    tick();
    chk("mid_thr_low", int'(bus.thr_low), 5);
    chk("mid_thr_high", int'(bus.thr_high), 6);
    bus.init = 1'b0;
    #1 chk("mid_pop_init_fall", int'(bus.pop_in), 0);
    tick();
    #1 chk("mid_pop_resume", int'(bus.pop_in), 4'b0100);
    tick();
    chk("mid_push_resume", int'(bus.push_out), 4'b0100);
    chk("mid_data_resume", int'(bus.data_out), 10'h2A2);

    // Reset mid-transfer drops the push that would have been registered.
    reset = 1'b1;
    tick();
    chk("rstmid_push", int'(bus.push_out), 0);
    chk("rstmid_data", int'(bus.data_out), 0);
    chk("rstmid_thr_low", int'(bus.thr_low), 0);
    chk("rstmid_idle", int'(bus.idle), 0);
    #1 chk("rstmid_pop", int'(bus.pop_in), 0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_router.md
Name: rr_arbiter_router

Overview:
- Central switching stage between the four input FIFOs (ports 0-3) and the four output FIFOs (ports 4-7).
- Pops the input FIFOs in round-robin order and steers each 10-bit word to the output FIFO selected by bits [9:8].
- Respects output almost-full back-pressure.
- Latches the limit_low/limit_high thresholds at init and distributes them to all FIFOs.

Parameters:
- DATA_W, 10, word width; destination field is the top DEST_W bits.
- DEST_W, 2, destination field width; port count fixed at 4.
- LIM_W, 3, threshold width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  configuration request; latches thresholds, halts arbitration while high.
- limit_low  in  LIM_W  almost-empty threshold, sampled in INIT.
- limit_high  in  LIM_W  almost-full threshold, sampled in INIT.
- in_empty  in  4  empty flags of input FIFOs 0-3.
- data0_in..data3_in  in  DATA_W each  head words of input FIFOs 0-3 (show-ahead, valid while not empty).
- pop_in  out  4  one-hot pop to input FIFOs 0-3.
- out_almost_full  in  4  almost-full flags of output FIFOs 4-7.
- data_out  out  DATA_W  word bus shared by all output FIFOs.
- push_out  out  4  one-hot push to output FIFOs 4-7.
- thr_low, thr_high  out  LIM_W each  latched thresholds to all FIFOs.
- idle  out  1  high in IDLE state.

Behaviour:
- Reset (reset=1 at edge):
  - State=RESET, rr_ptr=0.
  - push_out=0, data_out=0, thr_low=0, thr_high=0, idle=0.
  - pop_in=0 combinationally whenever state is not ACTIVE.
- FSM states: RESET, INIT, IDLE, ACTIVE.
  - RESET -> INIT on the first edge with reset=0.
  - INIT: thr_low<=limit_low and thr_high<=limit_high every cycle. Stay while init=1. When init=0: go to ACTIVE if any in_empty=0, else IDLE.
  - IDLE: idle=1. Go to ACTIVE when any in_empty=0.
  - ACTIVE: go to IDLE when all in_empty=1 and no grant was issued this cycle.
  - init=1 in IDLE or ACTIVE -> INIT next cycle. A push already registered still completes; no new grant in the cycle init is seen.
  - reset=1 overrides everything, in any state, mid-transfer included. A registered push is dropped.
- Grant (combinational, ACTIVE only):
  - Scan queues rr_ptr, rr_ptr+1, ... mod 4.
  - Grant the first queue i with in_empty[i]=0 and out_almost_full[datai_in[9:8]]=0.
  - A blocked queue is skipped; there is no head-of-line blocking across queues.
  - At most one grant per cycle; pop_in[i]=1 for that cycle only.
- Transfer latency is 1 cycle.
  - At the grant edge: data_out<=datai_in, push_out<=one-hot(datai_in[9:8]), rr_ptr<=(i+1) mod 4.
  - No grant: push_out<=0, data_out holds its last value.
  - Sustained throughput is one word per cycle.
- Back-pressure:
  - The almost-full check uses the current-cycle flag.
  - Downstream FIFOs must assert almost_full with at least 2 free entries, covering the 1-cycle push lag.
  - This block never checks full.
- rr_ptr is unchanged when no grant is issued. Wrap 3 -> 0.
- The destination field is never modified; data_out carries the full word.

Decomposition:
- Shared package (router_pkg):
  - DATA_W, DEST_W, LIM_W, NUM_PORTS=4.
  - FSM state encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
  - Function that returns the destination field of a word.
- One natural sub-module: rr_grant.
  - Purely combinational 4-way round-robin priority picker.
  - Inputs: request vector, rr_ptr. Outputs: one-hot grant, grant index.
  - The request vector is ~in_empty masked by destination almost-full.
- FSM, registers and muxing stay in rr_arbiter_router.

Test Plan:
- Reset values: reset=1 for 3 cycles with random inputs -> pop_in=0, push_out=0, data_out=0, thr_low=0, thr_high=0, idle=0.
- Init latch and state sequence:
  - Stimulus: init=1 with limit_low=3, limit_high=7, then init=0 with all queues empty.
  - Response: thr_low=3, thr_high=7; state goes INIT -> IDLE and idle=1.
- Single word:
  - Stimulus: queue 2 holds 10'b01_1010_0101; all other queues empty.
  - Response: pop_in=4'b0100 in cycle N; push_out=4'b0010 and data_out=0x1A5 in cycle N+1.
- Round-robin order:
  - Stimulus: all 4 queues each hold 6 words with dest = queue index; rr_ptr=0.
  - Response: grants repeat 0,1,2,3 for 24 consecutive cycles; push_out matches dest; the block then returns to IDLE.
- Back-pressure skip:
  - Stimulus: queues 0 and 1 non-empty, queue 0 head dest=3, out_almost_full=4'b1000.
  - Response: queue 1 is granted and queue 0 is held. When almost_full drops, queue 0 is granted next.
- Init and reset mid-operation:
  - Stimulus: init=1 during a continuous transfer.
  - Response: the pending push completes, then pop_in=0 until init falls.
  - Stimulus: reset=1 during a transfer.
  - Response: push_out=0 at the next edge.
